// File: rtl/pid_sched.sv
// ============================================================================
// Module      : pid_sched
// Description : Decimated PID update sequencer. It captures the error once per
//               period and saturates P+I+D into the 12-bit drive command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_sched #(
    parameter int DEC_BITS = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [12:0] error,
    input  logic               not_pedaling,
    output logic [11:0]        drv_mag,
    output logic               pid_vld,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_INTEG = 3'd2,
        S_DERIV = 3'd3,
        S_SUM   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [DEC_BITS-1:0] c_DEC_LAST  = '1;
    localparam logic signed [18:0]  c_INTEG_MAX = 19'sh1FFFF;
    localparam logic signed [13:0]  c_DIFF_MAX  = 14'sd255;
    localparam logic signed [13:0]  c_DIFF_MIN  = -14'sd256;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DEC_BITS-1:0]  r_dec;
    logic [12:0]          r_err_cap;
    logic                 r_np_cap;
    logic [17:0]          r_integ;
    logic [12:0]          r_prev_err;
    logic [11:0]          r_i_term;
    logic [9:0]           r_d_term;
    logic [14:0]          r_pid;
    logic [11:0]          r_drv_mag;
    logic                 r_pid_vld;

    logic                 w_tick;
    logic signed [18:0]   w_err_ext19;
    logic signed [18:0]   w_integ_sum;
    logic [17:0]          w_integ_nxt;
    logic signed [13:0]   w_diff;
    logic [8:0]           w_diff_sat;
    logic [14:0]          w_pid;
    logic [11:0]          w_drv;

    assign w_tick  = en && (r_dec == c_DEC_LAST) && (r_state == S_IDLE);
    assign busy    = (r_state != S_IDLE);
    assign drv_mag = r_drv_mag;
    assign pid_vld = r_pid_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec <= '0;
        end else if (en) begin
            r_dec <= r_dec + DEC_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_INTEG;
            S_INTEG: w_state_nxt = S_DERIV;
            S_DERIV: w_state_nxt = S_SUM;
            S_SUM:   w_state_nxt = S_OUT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Integrator clamps to the non-negative 17-bit range, so bit 17 stays clear.
    assign w_err_ext19 = {{6{r_err_cap[12]}}, r_err_cap};
    assign w_integ_sum = $signed({1'b0, r_integ}) + w_err_ext19;

    always_comb begin
        w_integ_nxt = w_integ_sum[17:0];
        if (r_np_cap) begin
            w_integ_nxt = 18'h0;
        end else if (w_integ_sum < 19'sd0) begin
            w_integ_nxt = 18'h0;
        end else if (w_integ_sum > c_INTEG_MAX) begin
            w_integ_nxt = 18'h1FFFF;
        end
    end

    assign w_diff = {r_err_cap[12], r_err_cap} - {r_prev_err[12], r_prev_err};

    always_comb begin
        w_diff_sat = w_diff[8:0];
        if (w_diff > c_DIFF_MAX) begin
            w_diff_sat = 9'h0FF;
        end else if (w_diff < c_DIFF_MIN) begin
            w_diff_sat = 9'h100;
        end
    end

    assign w_pid = {{2{r_err_cap[12]}}, r_err_cap}
                 + {3'b000, r_i_term}
                 + {{5{r_d_term[9]}}, r_d_term};

    // Sum range is -4608..8700: sign bit means negative, bits 13:12 mean > 4095.
    assign w_drv = r_pid[14]       ? 12'h000 :
                   (|r_pid[13:12]) ? 12'hFFF : r_pid[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cap  <= '0;
            r_np_cap   <= 1'b0;
            r_integ    <= '0;
            r_prev_err <= '0;
            r_i_term   <= '0;
            r_d_term   <= '0;
            r_pid      <= '0;
            r_drv_mag  <= '0;
            r_pid_vld  <= 1'b0;
        end else begin
            r_pid_vld <= (r_state == S_OUT);
            case (r_state)
                S_CAPT: begin
                    r_err_cap <= error;
                    r_np_cap  <= not_pedaling;
                end
                S_INTEG: begin
                    r_integ  <= w_integ_nxt;
                    r_i_term <= w_integ_nxt[16:5];
                end
                S_DERIV: begin
                    r_d_term   <= {w_diff_sat, 1'b0};
                    r_prev_err <= r_err_cap;
                end
                S_SUM:   r_pid     <= w_pid;
                S_OUT:   r_drv_mag <= w_drv;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
